// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver for the clock display.
// Scans NUM_DIGITS character codes onto one active-low segment bus with one-hot
// active-low anodes. Each digit slot starts with a ghosting guard interval.
// Every frame shows a snapshot of the inputs taken at frame position 0, and
// masked digits blink with a half-period of BLINK_FRAMES frames.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 4,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [5*NUM_DIGITS-1:0] char_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_start_o
);

  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  // ST_ORIGIN: scan parked at p=0, the next enabled edge takes the first snapshot
  // without advancing. ST_SCAN: counters advance on every enabled edge.
  typedef enum logic {
    ST_ORIGIN = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t                  r_state;
  logic [SLOT_W-1:0]       r_slotCnt;
  logic [DIG_W-1:0]        r_digitIdx;
  logic [FRM_W-1:0]        r_frameCnt;
  logic                    r_phase;
  logic [5*NUM_DIGITS-1:0] r_charSnap;
  logic [NUM_DIGITS-1:0]   r_dpSnap;
  logic [NUM_DIGITS-1:0]   r_maskSnap;
  logic                    r_phaseSnap;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frameStart;

  state_t                  w_nextState;
  logic [SLOT_W-1:0]       w_nextSlot;
  logic [DIG_W-1:0]        w_nextDigit;
  logic [FRM_W-1:0]        w_nextFrame;
  logic                    w_nextPhase;
  logic                    w_takeSnap;
  logic                    w_slotWrap;
  logic                    w_digitWrap;
  logic [5*NUM_DIGITS-1:0] w_snapChar;
  logic [NUM_DIGITS-1:0]   w_snapDp;
  logic [NUM_DIGITS-1:0]   w_snapMask;
  logic                    w_snapPhase;
  logic [4:0]              w_curChar;
  logic                    w_curDp;
  logic                    w_curMask;
  logic                    w_inGuard;
  logic [6:0]              w_nextSeg;
  logic                    w_nextDp;
  logic [NUM_DIGITS-1:0]   w_nextAn;
  logic                    w_nextFs;

  // Character code to active-low segments, bit6=a down to bit0=g.
  function automatic logic [6:0] decodeChar(input logic [4:0] code);
    logic [6:0] seg;
    case (code)
      5'd0:    seg = 7'b0000001;
      5'd1:    seg = 7'b1001111;
      5'd2:    seg = 7'b0010010;
      5'd3:    seg = 7'b0000110;
      5'd4:    seg = 7'b1001100;
      5'd5:    seg = 7'b0100100;
      5'd6:    seg = 7'b0100000;
      5'd7:    seg = 7'b0001111;
      5'd8:    seg = 7'b0000000;
      5'd9:    seg = 7'b0000100;
      5'd10:   seg = 7'b0001000;
      5'd11:   seg = 7'b0011000;
      5'd12:   seg = 7'b1111110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign w_slotWrap  = (r_slotCnt == SLOT_LAST);
  assign w_digitWrap = (r_digitIdx == DIG_LAST);

  // Next scan position, blink counters, and whether this edge starts a frame.
  always_comb begin
    w_nextState = r_state;
    w_nextSlot  = r_slotCnt;
    w_nextDigit = r_digitIdx;
    w_nextFrame = r_frameCnt;
    w_nextPhase = r_phase;
    w_takeSnap  = 1'b0;
    if (!enable) begin
      w_nextState = ST_ORIGIN;
      w_nextSlot  = '0;
      w_nextDigit = '0;
      w_nextFrame = '0;
      w_nextPhase = 1'b1;
    end else if (r_state == ST_ORIGIN) begin
      w_nextState = ST_SCAN;
      w_nextSlot  = '0;
      w_nextDigit = '0;
      w_takeSnap  = 1'b1;
    end else if (w_slotWrap) begin
      w_nextSlot = '0;
      if (w_digitWrap) begin
        w_nextDigit = '0;
        w_takeSnap  = 1'b1;
        if (r_frameCnt == FRM_LAST) begin
          w_nextFrame = '0;
          w_nextPhase = ~r_phase;
        end else begin
          w_nextFrame = r_frameCnt + 1'b1;
        end
      end else begin
        w_nextDigit = r_digitIdx + 1'b1;
      end
    end else begin
      w_nextSlot = r_slotCnt + 1'b1;
    end
  end

  // The new phase is captured with the new frame, so a toggle lands on the frame boundary.
  assign w_snapChar  = w_takeSnap ? char_i       : r_charSnap;
  assign w_snapDp    = w_takeSnap ? dp_i         : r_dpSnap;
  assign w_snapMask  = w_takeSnap ? blink_mask_i : r_maskSnap;
  assign w_snapPhase = w_takeSnap ? w_nextPhase  : r_phaseSnap;

  assign w_inGuard = (int'(w_nextSlot) < GUARD_CYCLES);

  // Select the snapshot fields of the digit that will be on display after this edge.
  always_comb begin
    w_curChar = 5'h1f;
    w_curDp   = 1'b0;
    w_curMask = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_nextDigit == DIG_W'(d)) begin
        w_curChar = w_snapChar[5*d +: 5];
        w_curDp   = w_snapDp[d];
        w_curMask = w_snapMask[d];
      end
    end
  end

  // Output values for the next cycle; anodes stay off during the guard, segments do not.
  always_comb begin
    w_nextSeg = 7'b1111111;
    w_nextDp  = 1'b1;
    w_nextAn  = '1;
    w_nextFs  = 1'b0;
    if (enable) begin
      w_nextFs = w_takeSnap;
      if (!(w_curMask && !w_snapPhase)) begin
        w_nextSeg = decodeChar(w_curChar);
        w_nextDp  = ~w_curDp;
      end
      if (!w_inGuard) begin
        w_nextAn = ~(NUM_DIGITS'(1) << w_nextDigit);
      end
    end
  end

  // Scan state, counters and the per-frame snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_ORIGIN;
      r_slotCnt   <= '0;
      r_digitIdx  <= '0;
      r_frameCnt  <= '0;
      r_phase     <= 1'b1;
      r_charSnap  <= '1;
      r_dpSnap    <= '0;
      r_maskSnap  <= '0;
      r_phaseSnap <= 1'b1;
    end else begin
      r_state     <= w_nextState;
      r_slotCnt   <= w_nextSlot;
      r_digitIdx  <= w_nextDigit;
      r_frameCnt  <= w_nextFrame;
      r_phase     <= w_nextPhase;
      r_charSnap  <= w_snapChar;
      r_dpSnap    <= w_snapDp;
      r_maskSnap  <= w_snapMask;
      r_phaseSnap <= w_snapPhase;
    end
  end

  // Registered display outputs, blanked immediately by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg        <= 7'b1111111;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frameStart <= 1'b0;
    end else begin
      r_seg        <= w_nextSeg;
      r_dp         <= w_nextDp;
      r_an         <= w_nextAn;
      r_frameStart <= w_nextFs;
    end
  end

  assign seg_o         = r_seg;
  assign dp_o          = r_dp;
  assign an_o          = r_an;
  assign frame_start_o = r_frameStart;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 8-cycle slots, 2-cycle guard
// and a 2-frame blink half-period. Outputs are sampled 1 time unit after each edge.
module tb_seg7_scan_driver;

  localparam int ND = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b0011000,
    7'b1111110, 7'b1111111, 7'b1111111, 7'b1111111
  };

  localparam logic [12:0] BLANK_VEC = {7'b1111111, 1'b1, 4'b1111, 1'b0};
  localparam logic [19:0] STD_CHARS = {5'd3, 5'd2, 5'd1, 5'd0};

  logic          clk;
  logic          reset;
  logic          enable;
  logic [5*ND-1:0] charIn;
  logic [ND-1:0] dpIn;
  logic [ND-1:0] maskIn;
  logic [6:0]    segOut;
  logic          dpOut;
  logic [ND-1:0] anOut;
  logic          frameStart;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (8),
    .GUARD_CYCLES(2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .char_i       (charIn),
    .dp_i         (dpIn),
    .blink_mask_i (maskIn),
    .seg_o        (segOut),
    .dp_o         (dpOut),
    .an_o         (anOut),
    .frame_start_o(frameStart)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {seg, dp, an, frame_start} after edge k for the digit codes 0,1,2,3
  // with no decimal points; digits set in blankDigits show blank segments.
  function automatic logic [12:0] expScan(input int k, input logic [3:0] blankDigits);
    int p;
    int d;
    int s;
    logic [6:0] seg;
    logic [3:0] an;
    p   = k % 32;
    d   = p / 8;
    s   = p % 8;
    seg = blankDigits[d] ? 7'b1111111 : SEG_TAB[d];
    an  = (s < 2) ? 4'b1111 : ~(4'b0001 << d);
    return {seg, 1'b1, an, (p == 0)};
  endfunction

  task automatic applyStimulus(input logic [5*ND-1:0] chars, input logic [ND-1:0] dps,
                               input logic [ND-1:0] mask);
    charIn = chars;
    dpIn   = dps;
    maskIn = mask;
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse reset low for two edges and release it so the next edge is edge 0.
  task automatic restartScan();
    reset = 1'b0;
    advance(2);
    reset = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [12:0] expected);
    logic [12:0] observed;
    observed = {segOut, dpOut, anOut, frameStart};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed seg=%b dp=%b an=%b fs=%b, expected seg=%b dp=%b an=%b fs=%b",
             tag, observed[12:6], observed[5], observed[4:1], observed[0],
             expected[12:6], expected[5], expected[4:1], expected[0]);
    end
  endtask

  initial begin
    int sweepCodes [17];
    logic [4:0] code;
    logic dpReq;
    logic [6:0] segExp;

    for (int i = 0; i < 16; i++) sweepCodes[i] = i;
    sweepCodes[16] = 31;

    // Reset held low: outputs blank.
    reset  = 1'b0;
    enable = 1'b1;
    applyStimulus(STD_CHARS, 4'b0000, 4'b0000);
    advance(3);
    checkOutput("reset_hold", BLANK_VEC);

    // Release reset: edge 0 snapshots, then two full frames of scan order.
    reset = 1'b1;
    for (int k = 0; k < 64; k++) begin
      advance(1);
      checkOutput($sformatf("scan_k%0d", k), expScan(k, 4'b0000));
    end

    // Decode sweep on digit 0, dp on odd codes.
    applyStimulus({5'd3, 5'd2, 5'd1, 5'(sweepCodes[0])}, 4'b0000, 4'b0000);
    restartScan();
    for (int i = 0; i < 17; i++) begin
      code   = 5'(sweepCodes[i]);
      dpReq  = code[0];
      segExp = (sweepCodes[i] < 16) ? SEG_TAB[sweepCodes[i]] : 7'b1111111;
      advance(1);
      checkOutput($sformatf("dec%0d_p0", sweepCodes[i]), {segExp, ~dpReq, 4'b1111, 1'b1});
      advance(2);
      checkOutput($sformatf("dec%0d_p2", sweepCodes[i]), {segExp, ~dpReq, 4'b1110, 1'b0});
      advance(8);
      checkOutput($sformatf("dec%0d_p10", sweepCodes[i]), {7'b1001111, 1'b1, 4'b1101, 1'b0});
      advance(21);
      if (i < 16) begin
        code  = 5'(sweepCodes[i+1]);
        dpReq = code[0];
        applyStimulus({5'd3, 5'd2, 5'd1, code}, {3'b000, dpReq}, 4'b0000);
      end
    end

    // No tearing: change digit 0 from 8 to 1 mid-slot.
    applyStimulus({5'd3, 5'd2, 5'd1, 5'd8}, 4'b0000, 4'b0000);
    restartScan();
    advance(1);
    advance(5);
    checkOutput("tear_p5", {7'b0000000, 1'b1, 4'b1110, 1'b0});
    applyStimulus({5'd3, 5'd2, 5'd1, 5'd1}, 4'b0000, 4'b0000);
    advance(1);
    checkOutput("tear_p6", {7'b0000000, 1'b1, 4'b1110, 1'b0});
    advance(1);
    checkOutput("tear_p7", {7'b0000000, 1'b1, 4'b1110, 1'b0});
    advance(1);
    checkOutput("tear_p8", {7'b1001111, 1'b1, 4'b1111, 1'b0});
    advance(24);
    checkOutput("tear_next_p0", {7'b1001111, 1'b1, 4'b1111, 1'b1});
    advance(2);
    checkOutput("tear_next_p2", {7'b1001111, 1'b1, 4'b1110, 1'b0});

    // Blink digit 1: visible frames 0-1, blank 2-3, visible again in frame 4.
    applyStimulus(STD_CHARS, 4'b0000, 4'b0010);
    restartScan();
    for (int k = 0; k < 160; k++) begin
      advance(1);
      checkOutput($sformatf("blink_k%0d", k),
                  expScan(k, ((k / 32) == 2 || (k / 32) == 3) ? 4'b0010 : 4'b0000));
    end

    // Enable dropped mid-frame, then raised again.
    applyStimulus(STD_CHARS, 4'b0000, 4'b0000);
    restartScan();
    advance(1);
    advance(13);
    checkOutput("en_p13", expScan(13, 4'b0000));
    enable = 1'b0;
    advance(1);
    checkOutput("en_low1", BLANK_VEC);
    advance(1);
    checkOutput("en_low2", BLANK_VEC);
    enable = 1'b1;
    advance(1);
    checkOutput("en_restart_p0", expScan(0, 4'b0000));
    advance(20);
    checkOutput("en_p20", expScan(20, 4'b0000));

    // Asynchronous reset mid-slot blanks before the next clock edge.
    reset = 1'b0;
    #1;
    checkOutput("async_reset", BLANK_VEC);
    advance(1);
    checkOutput("reset_after_edge", BLANK_VEC);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed 7-segment driver for the clock's multi-digit display. It time-multiplexes NUM_DIGITS character codes onto one shared active-low segment bus and drives one-hot active-low digit anodes. Each digit slot starts with a ghosting guard interval. Per-digit blinking supports set-mode editing. It sits between the timekeeping/mode logic and the board's display pins, and replaces single-digit decoders such as the AM/PM indicator.

## Interface
- NUM_DIGITS, 6: digits scanned, 1..8.
- REFRESH_DIV, 100000: clk cycles per digit slot, must be > GUARD_CYCLES.
- GUARD_CYCLES, 4: cycles at the start of each slot with all anodes off, 0 allowed.
- BLINK_FRAMES, 50: full frames per blink half-period, ≥1.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; low forces the reset state immediately.
- enable  in  1  synchronous; low blanks the display and holds the scan at its origin.
- char_i  in  5*NUM_DIGITS  character code per digit; digit d uses bits [5d+4:5d]; digit 0 is scanned first.
- dp_i  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blink_mask_i  in  NUM_DIGITS  1 = digit blinks.
- seg_o  out  7  segments, bit6=a … bit0=g, active-low.
- dp_o  out  1  decimal point, active-low.
- an_o  out  NUM_DIGITS  digit anodes, active-low, at most one low.
- frame_start_o  out  1  one-cycle pulse when a new frame's snapshot is taken.

## Operation
- Character decode, 7-bit seg_o with a–g active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 10 "A"=0001000, 11 "P"=0011000, 12 "-"=1111110
  - 13..31 blank=1111111
- Counters:
  - slot_cnt runs 0..REFRESH_DIV-1.
  - digit_idx runs 0..NUM_DIGITS-1; it advances when slot_cnt wraps and itself wraps to 0.
  - Frame position p = digit_idx*REFRESH_DIV + slot_cnt.
- Snapshot: on every edge where the new p is 0, latch char_i, dp_i, blink_mask_i and the blink phase.
  - The whole frame displays the snapshot, so there is no tearing.
  - frame_start_o is high for exactly that cycle.
- Blink:
  - frame_cnt counts completed frames.
  - On the frame wrap where frame_cnt==BLINK_FRAMES-1, frame_cnt clears and phase toggles.
  - Phase 1 = visible, and is the reset value.
  - While the latched phase is 0, digits with a latched mask bit output seg_o=1111111 and dp_o=1; their anode still scans.
- Anodes:
  - an_o is all 1 while slot_cnt < GUARD_CYCLES.
  - Otherwise only bit digit_idx is 0.
  - seg_o and dp_o present the current digit_idx for the entire slot, including the guard.
- enable low:
  - On each edge, slot_cnt, digit_idx, frame_cnt clear and phase is set to 1.
  - Outputs are driven all 1 and frame_start_o=0.
  - The first edge with enable high behaves as the reset-exit edge: p=0, snapshot taken.

## Timing
- Reset state (asynchronous, while reset low): seg_o=1111111, dp_o=1, an_o all 1, frame_start_o=0, all counters 0, phase=1, snapshot = blank codes.
- All outputs are registered and reflect the counter values updated on the same edge.
- Edge k is the k-th rising edge with reset high and enable high, counting from 0. After edge k, p = k mod (NUM_DIGITS*REFRESH_DIV).
- Edge 0 takes the first snapshot and pulses frame_start_o.
- Frame length is NUM_DIGITS*REFRESH_DIV cycles.
- An input change is displayed at the next snapshot: latency is 1..frame length cycles.
- Blink half-period is BLINK_FRAMES frames and always changes on a frame boundary.
- Reset asserted mid-slot: outputs are blank immediately, without waiting for clk; the scan restarts at digit 0.
- Simultaneous frame wrap and blink toggle: the new phase applies to the new frame.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, BLINK_FRAMES=2.
- Reset: hold reset=0 for 3 cycles -> seg_o=1111111, an_o=1111, dp_o=1, frame_start_o=0. Release reset with enable=1 -> frame_start_o=1 on edge 0 only.
- Scan order: char_i={3,2,1,0}, no blink -> an_o=1111 for 2 cycles, then 1110 for 6 cycles with seg_o=0000001. Then digit 1 follows the same pattern with seg_o=1001111, and so on; frame_start_o pulses every 32 cycles.
- Decode sweep: drive codes 0..15 on digit 0 across frames -> patterns as listed; 10 gives 0001000, 11 gives 0011000, 13–15 give 1111111. dp_i[0]=1 gives dp_o=0 during slot 0.
- No tearing: change char_i[4:0] from 8 to 1 at p=5 -> digit 0 keeps showing 0000000 until the next frame_start_o, then shows 1001111.
- Blink: blink_mask_i=0010 -> digit 1 is visible in frames 0–1, blank in frames 2–3 (seg_o=1111111, an_o=1101 still asserted), and visible again in frame 4. Other digits are never blanked.
- enable/reset mid-frame: drop enable at p=13 -> next edge gives an_o=1111. Raise enable -> frame_start_o pulses and digit 0 restarts. Asserting reset at p=20 blanks outputs before the next clk edge.
